// File: rtl/hazard_pkg.sv
// Shared types and encodings for the LEGv8 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_t;

  localparam logic [4:0] XZR     = 5'd31;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // X31 reads as zero, so it never matches as a hazard source.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != XZR) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the pipeline side.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       rs1_D, rs2_D;
  logic [4:0]       rs1_E, rs2_E;
  logic [4:0]       rd_E;
  logic             memRead_E;
  logic [4:0]       rd_M;
  logic             regWrite_M;
  logic [4:0]       rd_W;
  logic             regWrite_W;
  logic             branchTaken_M;
  logic             halt_req;
  logic [1:0]       fwdA_E, fwdB_E;
  logic             stall_F, stall_D;
  logic             flush_D, flush_E, flush_M;
  logic             halted;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, memRead_E,
           rd_M, regWrite_M, rd_W, regWrite_W, branchTaken_M, halt_req,
    input  fwdA_E, fwdB_E, stall_F, stall_D, flush_D, flush_E, flush_M,
           halted, stallCount, flushCount
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, memRead_E,
           rd_M, regWrite_M, rd_W, regWrite_W, branchTaken_M, halt_req,
    output fwdA_E, fwdB_E, stall_F, stall_D, flush_D, flush_E, flush_M,
           halted, stallCount, flushCount
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding source select for one execute-stage ALU operand.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_M,
  input  logic       regWrite_M,
  input  logic [4:0] rd_W,
  input  logic       regWrite_W,
  output logic [1:0] sel
);

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    sel = FWD_REG;
    if (regWrite_M && reg_match(rd_M, rs))
      sel = FWD_MEM;
    else if (regWrite_W && reg_match(rd_W, rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush,
// halt/drain FSM and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t      state_q;
  logic             halted_q;
  logic [DW-1:0]    dcnt_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             luh;
  logic             br;
  logic             frozen;

  fwd_sel u_fwd_a (
    .rs         (bus.rs1_E),
    .rd_M       (bus.rd_M),
    .regWrite_M (bus.regWrite_M),
    .rd_W       (bus.rd_W),
    .regWrite_W (bus.regWrite_W),
    .sel        (bus.fwdA_E)
  );

  fwd_sel u_fwd_b (
    .rs         (bus.rs2_E),
    .rd_M       (bus.rd_M),
    .regWrite_M (bus.regWrite_M),
    .rd_W       (bus.rd_W),
    .regWrite_W (bus.regWrite_W),
    .sel        (bus.fwdB_E)
  );

  assign luh    = bus.memRead_E &&
                  (reg_match(bus.rd_E, bus.rs1_D) || reg_match(bus.rd_E, bus.rs2_D));
  assign br     = bus.branchTaken_M;
  assign frozen = (state_q != RUN);

  // A taken branch releases the PC hold so the target is captured, even while draining.
  always_comb begin
    bus.stall_F = (luh || frozen) && !br;
    bus.stall_D = luh && !br;
    bus.flush_D = br || frozen;
    bus.flush_E = br || luh;
    bus.flush_M = br;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.halt_req) begin
            state_q <= DRAIN;
            dcnt_q  <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!luh) begin
            if (dcnt_q == '0) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q - 1'b1;
            end
          end
        end
        HALTED: begin
          if (!bus.halt_req) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (luh && !br && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (br && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.halted     = halted_q;
  assign bus.stallCount = stall_cnt_q;
  assign bus.flushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (CNT_W = 4 to reach saturation).
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs1_D = '0; bus.rs2_D = '0; bus.rs1_E = '0; bus.rs2_E = '0;
    bus.rd_E = '0; bus.memRead_E = 1'b0; bus.rd_M = '0; bus.regWrite_M = 1'b0;
    bus.rd_W = '0; bus.regWrite_W = 1'b0; bus.branchTaken_M = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  task automatic set_luh(input logic on);
    bus.memRead_E = on;
    bus.rd_E      = 5'd3;
    bus.rs2_D     = 5'd3;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    reset = 1'b1;
    #12;
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_stallcnt", 32'(bus.stallCount), 32'd0);
    chk("rst_flushcnt", 32'(bus.flushCount), 32'd0);
    chk("rst_stallF", 32'(bus.stall_F), 32'd0);
    chk("rst_flushD", 32'(bus.flush_D), 32'd0);
    reset = 1'b0;
    tick();

    // Forwarding
    bus.regWrite_M = 1'b1; bus.rd_M = 5'd5;
    bus.regWrite_W = 1'b1; bus.rd_W = 5'd5;
    bus.rs1_E = 5'd5; bus.rs2_E = 5'd31;
    #1;
    chk("fwdA_mem_prio", 32'(bus.fwdA_E), 32'h2);
    bus.rd_M = 5'd31;
    #1;
    chk("fwdB_xzr", 32'(bus.fwdB_E), 32'h0);
    chk("fwdA_wb", 32'(bus.fwdA_E), 32'h1);
    bus.rs2_E = 5'd7; bus.rd_W = 5'd7; bus.rd_M = 5'd7; bus.regWrite_M = 1'b0;
    #1;
    chk("fwdB_wb_nomemwr", 32'(bus.fwdB_E), 32'h1);
    chk("fwdA_none", 32'(bus.fwdA_E), 32'h0);
    bus.regWrite_W = 1'b0;
    #1;
    chk("fwdB_nowr", 32'(bus.fwdB_E), 32'h0);
    bus.rd_W = 5'd31; bus.rs2_E = 5'd31; bus.regWrite_W = 1'b1;
    #1;
    chk("fwdB_wb_xzr", 32'(bus.fwdB_E), 32'h0);
    clear_inputs();

    // Load-use stall
    set_luh(1'b1);
    #1;
    chk("luh_stallF", 32'(bus.stall_F), 32'd1);
    chk("luh_stallD", 32'(bus.stall_D), 32'd1);
    chk("luh_flushE", 32'(bus.flush_E), 32'd1);
    chk("luh_flushD", 32'(bus.flush_D), 32'd0);
    tick();
    chk("luh_stallcnt", 32'(bus.stallCount), 32'd1);
    set_luh(1'b0);
    #1;
    chk("luh_release", 32'(bus.stall_F), 32'd0);
    bus.memRead_E = 1'b1; bus.rd_E = 5'd31; bus.rs1_D = 5'd31;
    #1;
    chk("luh_xzr", 32'(bus.stall_F), 32'd0);
    clear_inputs();

    // Branch overrides load-use
    set_luh(1'b1);
    bus.branchTaken_M = 1'b1;
    #1;
    chk("br_flushD", 32'(bus.flush_D), 32'd1);
    chk("br_flushE", 32'(bus.flush_E), 32'd1);
    chk("br_flushM", 32'(bus.flush_M), 32'd1);
    chk("br_stallF", 32'(bus.stall_F), 32'd0);
    chk("br_stallD", 32'(bus.stall_D), 32'd0);
    tick();
    chk("br_flushcnt", 32'(bus.flushCount), 32'd1);
    chk("br_stallcnt", 32'(bus.stallCount), 32'd1);
    clear_inputs();

    // Drain, no hazards: halted from t+5
    bus.halt_req = 1'b1;
    tick();
    chk("drain_stallF", 32'(bus.stall_F), 32'd1);
    chk("drain_flushD", 32'(bus.flush_D), 32'd1);
    bus.halt_req = 1'b0;
    tick(); tick(); tick();
    chk("drain_t4_halted", 32'(bus.halted), 32'd0);
    tick();
    chk("drain_t5_halted", 32'(bus.halted), 32'd1);
    chk("halted_stallF", 32'(bus.stall_F), 32'd1);
    tick();
    chk("unhalt", 32'(bus.halted), 32'd0);
    chk("unhalt_stallF", 32'(bus.stall_F), 32'd0);

    // Drain with one load-use cycle: halted from t+6
    bus.halt_req = 1'b1;
    tick();
    tick();
    set_luh(1'b1);
    #1;
    chk("drain_luh_stallD", 32'(bus.stall_D), 32'd1);
    tick();
    chk("drain_luh_stallcnt", 32'(bus.stallCount), 32'd2);
    set_luh(1'b0);
    tick(); tick();
    chk("drain_luh_t5", 32'(bus.halted), 32'd0);
    tick();
    chk("drain_luh_t6", 32'(bus.halted), 32'd1);
    tick();
    chk("halt_hold", 32'(bus.halted), 32'd1);
    bus.halt_req = 1'b0;
    tick();
    chk("unhalt2", 32'(bus.halted), 32'd0);

    // Branch in the same cycle as halt_req, then branch during DRAIN
    bus.halt_req = 1'b1;
    bus.branchTaken_M = 1'b1;
    #1;
    chk("brhalt_flushM", 32'(bus.flush_M), 32'd1);
    tick();
    chk("brdrain_stallF", 32'(bus.stall_F), 32'd0);
    chk("brdrain_flushD", 32'(bus.flush_D), 32'd1);
    bus.branchTaken_M = 1'b0;
    #1;
    chk("drain_after_br", 32'(bus.stall_F), 32'd1);
    tick();

    // Asynchronous reset mid-drain
    #2;
    reset = 1'b1;
    #1;
    chk("arst_halted", 32'(bus.halted), 32'd0);
    chk("arst_stallcnt", 32'(bus.stallCount), 32'd0);
    chk("arst_flushcnt", 32'(bus.flushCount), 32'd0);
    chk("arst_stallF", 32'(bus.stall_F), 32'd0);
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_stallF", 32'(bus.stall_F), 32'd0);
    chk("post_rst_halted", 32'(bus.halted), 32'd0);

    // Flush counter saturation
    bus.branchTaken_M = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("flush_14", 32'(bus.flushCount), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("flush_sat", 32'(bus.flushCount), 32'd15);
    chk("sat_stallcnt", 32'(bus.stallCount), 32'd0);
    bus.branchTaken_M = 1'b0;

    // Stall counter saturation
    set_luh(1'b1);
    for (int i = 0; i < 18; i++) tick();
    chk("stall_sat", 32'(bus.stallCount), 32'd15);
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 64-bit LEGv8 five-stage pipeline (fetch, decode, execute, memory, writeback). It selects the forwarding sources for the two execute-stage ALU operands. It stalls fetch and decode on load-use hazards and flushes wrong-path stages when a branch is taken. It also runs a halt/drain state machine that empties the pipeline on request, and keeps saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 32: width of each performance counter.
- DRAIN_CYCLES, 4: number of effective drain cycles before the block reports halted.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1_D, rs2_D  in  5  source registers of the instruction in decode.
- rs1_E, rs2_E  in  5  source registers of the instruction in execute.
- rd_E  in  5  destination register in execute.
- memRead_E  in  1  instruction in execute is a load.
- rd_M  in  5  destination register in memory.
- regWrite_M  in  1  instruction in memory writes the register file.
- rd_W  in  5  destination register in writeback.
- regWrite_W  in  1  instruction in writeback writes the register file.
- branchTaken_M  in  1  branch resolved taken in memory (PCSrc).
- halt_req  in  1  level request to drain and halt the pipeline.
- fwdA_E, fwdB_E  out  2  ALU operand A/B source: 00 = register file, 10 = memory-stage ALU result, 01 = writeback data.
- stall_F  out  1  hold the PC.
- stall_D  out  1  hold the IF/ID register.
- flush_D, flush_E, flush_M  out  1  load a bubble into IF/ID, ID/EX, EX/MEM.
- halted  out  1  pipeline is empty and fetch is frozen.
- stallCount  out  CNT_W  number of load-use stall cycles.
- flushCount  out  CNT_W  number of taken-branch flush events.

## Operation
- Register X31 (XZR) never creates a hazard. Any comparison against rd = 31 is false.
- Forwarding, per operand, using rs1_E for A and rs2_E for B:
  - 10 if regWrite_M and rd_M matches.
  - else 01 if regWrite_W and rd_W matches.
  - else 00.
  - The memory stage has priority over writeback.
- Load-use hazard (luh): memRead_E, and rd_E equals rs1_D or rs2_D.
  - Response: stall_F = stall_D = flush_E = 1.
- Taken branch: branchTaken_M gives flush_D = flush_E = flush_M = 1 and forces stall_F = stall_D = 0, so the PC captures the target.
- Priority: branch overrides luh. When both occur, no stall is issued and stallCount does not increment.
- FSM states: RUN, DRAIN, HALTED; reset state RUN.
  - RUN: if halt_req, go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - DRAIN:
    - stall_F = 1 and flush_D = 1, so fetch is frozen and bubbles enter decode.
    - The counter decrements only in cycles without luh.
    - When the counter is 0 and there is no luh, go to HALTED.
    - Dropping halt_req does not abort DRAIN.
  - HALTED: halted = 1, stall_F = 1, flush_D = 1. Go to RUN when halt_req = 0.
  - A taken branch during DRAIN still clears stall_F that cycle, so the target is latched. DRAIN continues and the counter decrements normally.
- Counters:
  - stallCount increments on each cycle in which luh stalls (luh and not branchTaken_M).
  - flushCount increments on each cycle in which branchTaken_M = 1.
  - Both saturate at 2^CNT_W - 1.

## Timing
- fwdA_E, fwdB_E, stall_F, stall_D and the flush_* outputs are combinational, valid in the same cycle as their inputs.
  - They are also a function of the current FSM state.
- FSM state, halted, the drain counter and both counters are registered.
- Latency: halt_req sampled high in RUN at cycle t gives DRAIN at t+1..t+4 (with no luh), then halted = 1 from t+5. Each luh cycle during DRAIN adds one cycle.
- HALTED with halt_req low at cycle t: RUN and halted = 0 from t+1.
- While reset is asserted, and on its release:
  - state RUN, halted = 0, stallCount = flushCount = 0, drain counter = 0.
  - Combinational outputs follow the RUN equations.
- Reset during DRAIN or HALTED returns to RUN immediately (asynchronously). No halted pulse is produced.
- halt_req and branchTaken_M in the same RUN cycle: the flush applies and the FSM enters DRAIN.

## Structure
- Shared package hazard_pkg holds:
  - typedef enum ctrl_state_t {RUN, DRAIN, HALTED}.
  - localparam XZR = 5'd31.
  - FWD_REG = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01.
- Sub-module fwd_sel: combinational forwarding selector for one operand. Inputs rs, rd_M, regWrite_M, rd_W, regWrite_W; output 2-bit select. It is instantiated twice, for A and B.
- The FSM, the drain counter and the saturating counters live in hazard_ctrl.

## Test plan
- Forwarding: regWrite_M = 1, rd_M = 5, regWrite_W = 1, rd_W = 5, rs1_E = 5 -> fwdA_E = 10. With rs2_E = 31 and rd_M = 31 -> fwdB_E = 00.
- Load-use: memRead_E = 1, rd_E = 3, rs2_D = 3 -> stall_F = stall_D = flush_E = 1 for exactly that cycle, and stallCount goes 0 -> 1.
- Branch over luh: same luh with branchTaken_M = 1 -> flush_D = flush_E = flush_M = 1, stall_F = 0, flushCount = 1, stallCount unchanged.
- Drain:
  - halt_req = 1 at cycle 10, no hazards -> halted = 1 at cycle 15.
  - Repeat with one luh cycle at cycle 12 -> halted = 1 at cycle 16.
  - Then drop halt_req -> halted = 0 the next cycle.
- Reset at cycle 2 of DRAIN -> state RUN, halted = 0, both counters 0 immediately. stall_F = 0 on the following cycle if there is no luh.
- Saturation with CNT_W = 4: 20 consecutive branchTaken_M cycles -> flushCount = 15.
